witf_sb: RTL and testbench
==========================

Name: witf_sb

Overview:
- Parametrised writeback instruction-track FIFO / scoreboard; the next generation of the single-issue writeback tracker.
- Sits between decode/dispatch and writeback. Records the destination register of each dispatched register-writing instruction in program order.
- Blocks dispatch on RAW hazards against any of NSRC source operands, and optionally on WAW hazards. Retires entries in order at writeback.
- Adds over the previous tracker: a dispatch valid/ready handshake, source/destination enables, x0 filtering, a flush, any depth (not only powers of two), an occupancy count, head readout, and a sticky underflow error.

Parameters:
- DEPTH, 4, number of in-flight entries; any value >= 1, need not be a power of two.
- AW, 5, register index width.
- NSRC, 2, number of source operands checked per dispatch (1..3).
- WAW_CHK, 0, when 1 a destination match also blocks dispatch.
- CW, 3, count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  dispatch accepted this cycle when high together with disp_valid.
- disp_rs  in  NSRC*AW  source indices; operand k occupies bits [k*AW +: AW].
- disp_rs_en  in  NSRC  per-source enable.
- disp_rd  in  AW  destination index.
- disp_rd_wen  in  1  instruction writes rd.
- wb_valid  in  1  head instruction writes back this cycle.
- wb_rdidx  out  AW  rd index of the head entry; 0 when empty.
- wb_tag  out  CW  slot index of the head entry (read pointer).
- flush  in  1  discard all entries.
- raw  out  1  RAW hazard (combinational).
- waw  out  1  WAW hazard (combinational).
- full  out  1  DEPTH entries valid.
- empty  out  1  no entries valid.
- count  out  CW  number of valid entries.
- err_uflow  out  1  sticky: wb_valid was seen while empty.

Behaviour:
- Reset (rst==0 at a clock edge) clears: all valid bits, write and read pointers and wrap flags, count, err_uflow.
- Reset outputs: empty=1, full=0, count=0, wb_rdidx=0, wb_tag=0, raw=0, waw=0, disp_ready=1.
- Reset has priority over every other input. A reset mid-operation drops all entries.
- Pointers run 0..DEPTH-1 and wrap to 0 explicitly, toggling a wrap flag.
  - empty = pointers equal and flags equal.
  - full = pointers equal and flags differ.
  - DEPTH==1: pointers are constant 0; full/empty come from the valid bit.
- Match for entry i, source k: vld[i] & disp_rs_en[k] & (disp_rs[k] != 0) & (rdidx[i] == disp_rs[k]).
  - raw = OR of all entry matches over all sources. Every source is checked (fixes the duplicated-rs1 defect of the previous generation).
- waw = OR over i of vld[i] & disp_rd_wen & (disp_rd != 0) & (rdidx[i] == disp_rd); forced to 0 when WAW_CHK==0.
- disp_ready = !raw & !(WAW_CHK & waw) & (!full | !alloc_need).
  - alloc_need = disp_rd_wen & (disp_rd != 0).
  - disp_ready depends only on registered state and dispatch inputs, never on wb_valid or flush.
- Accept = disp_valid & disp_ready. On accept with alloc_need: write disp_rd into slot wptr, set vld, advance wptr.
  - Accept without alloc_need (no write, or rd==x0) allocates nothing.
- Retire = wb_valid & !empty: clear vld[rptr], advance rptr.
  - wb_valid while empty: no state change; err_uflow set to 1 and held until reset.
- Same-cycle allocate and retire: both occur, count unchanged. Entries being retired still count as hazards that cycle (conservative, one extra stall cycle).
- Full and retire in the same cycle: dispatch still stalls that cycle; it is accepted the next cycle.
- flush: clears all vld bits, pointers, flags and count next cycle, overriding any same-cycle allocate or retire. err_uflow is not cleared.
- count += alloc - retire; always equals the popcount of the valid bits.
- Latency: a hazard clears in the cycle after the retiring wb_valid edge. A new entry is visible to raw in the cycle after its accept.

Test Plan:
- Reset then RAW: dispatch rd=5 (accepted). Next cycle rs[0]=5, rs_en=01 -> raw=1, disp_ready=0. Pulse wb_valid -> following cycle raw=0, disp_ready=1.
- Second-source check: entry rd=7; dispatch rs[0]=3, rs[1]=7, rs_en=11 -> raw=1. With rs_en=01 -> raw=0.
- x0 and wen filtering: dispatch rd=0 with wen=1, and rd=9 with wen=0 -> count stays 0, empty=1. rs=0 never raises raw.
- Fill and wrap, DEPTH=3: allocate rd=1,2,3 -> full=1, count=3, further alloc stalls. Retire + alloc in the same cycle -> next cycle alloc accepted. Ten alloc/retire pairs -> wb_rdidx follows program order across wrap; count never exceeds 3.
- WAW_CHK=1: entry rd=4; dispatch rd=4, no sources -> waw=1, disp_ready=0. With WAW_CHK=0 -> accepted, count=2.
- Flush/underflow: 2 entries, assert flush with simultaneous disp_valid and wb_valid -> next cycle empty=1, count=0. Then wb_valid while empty -> err_uflow=1, held until rst low.

Source files
------------

// File: rtl/witf_sb.sv
// Writeback instruction-track FIFO: records in-flight destination registers in
// program order, stalls dispatch on RAW (and optionally WAW) hazards, retires in order.
module witf_sb #(
  parameter int DEPTH   = 4,
  parameter int AW      = 5,
  parameter int NSRC    = 2,
  parameter int WAW_CHK = 0,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [NSRC*AW-1:0] disp_rs,
  input  logic [NSRC-1:0]    disp_rs_en,
  input  logic [AW-1:0]      disp_rd,
  input  logic               disp_rd_wen,
  input  logic               wb_valid,
  output logic [AW-1:0]      wb_rdidx,
  output logic [CW-1:0]      wb_tag,
  input  logic               flush,
  output logic               raw,
  output logic               waw,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count,
  output logic               err_uflow
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  // Handshake: a dispatch is accepted on a rising edge where disp_valid and
  // disp_ready are both high; disp_ready never depends on wb_valid or flush.

  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_rdidx [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic             r_wflag;
  logic             r_rflag;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_raw;
  logic          w_waw;
  logic          w_alloc_need;
  logic          w_ready;
  logic          w_alloc;
  logic          w_retire;
  logic [AW-1:0] w_head;

  function automatic logic [CW-1:0] f_next(input logic [CW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A single-entry FIFO has constant pointers, so occupancy comes from the valid bit.
  always_comb begin
    if (DEPTH == 1) begin
      w_empty = !r_vld[0];
      w_full  = r_vld[0];
    end else begin
      w_empty = (r_wptr == r_rptr) && (r_wflag == r_rflag);
      w_full  = (r_wptr == r_rptr) && (r_wflag != r_rflag);
    end
  end

  always_comb begin
    w_raw = 1'b0;
    w_waw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NSRC; k++) begin
        if (r_vld[i] && disp_rs_en[k] && (disp_rs[k*AW +: AW] != '0) &&
            (r_rdidx[i] == disp_rs[k*AW +: AW]))
          w_raw = 1'b1;
      end
      if ((WAW_CHK != 0) && r_vld[i] && disp_rd_wen && (disp_rd != '0) &&
          (r_rdidx[i] == disp_rd))
        w_waw = 1'b1;
    end
  end

  always_comb begin
    w_head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_empty && (r_rptr == CW'(i)))
        w_head = r_rdidx[i];
    end
  end

  assign w_alloc_need = disp_rd_wen && (disp_rd != '0);
  assign w_ready      = !w_raw && !w_waw && (!w_full || !w_alloc_need);
  assign w_alloc      = disp_valid && w_ready && w_alloc_need;
  assign w_retire     = wb_valid && !w_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wflag <= 1'b0;
      r_rflag <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_rdidx[i] <= '0;
    end else begin
      if (wb_valid && w_empty) r_err <= 1'b1;
      if (flush) begin
        r_vld   <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_wflag <= 1'b0;
        r_rflag <= 1'b0;
        r_count <= '0;
      end else begin
        // Retire clears before allocate sets, so allocate wins on a shared slot.
        for (int i = 0; i < DEPTH; i++) begin
          if (w_retire && (r_rptr == CW'(i))) r_vld[i] <= 1'b0;
          if (w_alloc && (r_wptr == CW'(i))) begin
            r_vld[i]   <= 1'b1;
            r_rdidx[i] <= disp_rd;
          end
        end
        if (w_alloc) begin
          r_wptr <= f_next(r_wptr);
          if (r_wptr == LAST) r_wflag <= ~r_wflag;
        end
        if (w_retire) begin
          r_rptr <= f_next(r_rptr);
          if (r_rptr == LAST) r_rflag <= ~r_rflag;
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_retire);
      end
    end
  end

  assign disp_ready = w_ready;
  assign wb_rdidx   = w_head;
  assign wb_tag     = r_rptr;
  assign raw        = w_raw;
  assign waw        = w_waw;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign err_uflow  = r_err;

endmodule

// File: tb/tb_witf_sb.sv
// Directed bench for witf_sb: instance a (DEPTH=3, no WAW check) and
// instance b (DEPTH=4, WAW check) driven by the same inputs.
module tb_witf_sb;
  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int CW   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               disp_valid;
  logic [NSRC*AW-1:0] disp_rs;
  logic [NSRC-1:0]    disp_rs_en;
  logic [AW-1:0]      disp_rd;
  logic               disp_rd_wen;
  logic               wb_valid;
  logic               flush;

  logic          a_ready, a_raw, a_waw, a_full, a_empty, a_err;
  logic [AW-1:0] a_rdidx;
  logic [CW-1:0] a_tag, a_count;
  logic          b_ready, b_raw, b_waw, b_full, b_empty, b_err;
  logic [AW-1:0] b_rdidx;
  logic [CW-1:0] b_tag, b_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q[$];

  witf_sb #(.DEPTH(3), .AW(AW), .NSRC(NSRC), .WAW_CHK(0), .CW(CW)) dut_a (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(a_ready),
    .disp_rs(disp_rs), .disp_rs_en(disp_rs_en), .disp_rd(disp_rd),
    .disp_rd_wen(disp_rd_wen), .wb_valid(wb_valid), .wb_rdidx(a_rdidx),
    .wb_tag(a_tag), .flush(flush), .raw(a_raw), .waw(a_waw), .full(a_full),
    .empty(a_empty), .count(a_count), .err_uflow(a_err)
  );

  witf_sb #(.DEPTH(4), .AW(AW), .NSRC(NSRC), .WAW_CHK(1), .CW(CW)) dut_b (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(b_ready),
    .disp_rs(disp_rs), .disp_rs_en(disp_rs_en), .disp_rd(disp_rd),
    .disp_rd_wen(disp_rd_wen), .wb_valid(wb_valid), .wb_rdidx(b_rdidx),
    .wb_tag(b_tag), .flush(flush), .raw(b_raw), .waw(b_waw), .full(b_full),
    .empty(b_empty), .count(b_count), .err_uflow(b_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid  = 1'b0;
    disp_rs     = '0;
    disp_rs_en  = '0;
    disp_rd     = '0;
    disp_rd_wen = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input logic [AW-1:0] rd, input logic wen);
    disp_valid  = 1'b1;
    disp_rd     = rd;
    disp_rd_wen = wen;
  endtask

  initial begin
    idle();
    // Reset state, observed while rst is still low
    tick();
    tick();
    #1;
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_count", a_count, 0);
    chk("rst_rdidx", a_rdidx, 0);
    chk("rst_tag", a_tag, 0);
    chk("rst_raw", a_raw, 0);
    chk("rst_waw", b_waw, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_err", a_err, 0);
    rst = 1'b1;
    tick();

    // RAW on source 0, cleared by writeback
    dispatch(5'd5, 1'b1);
    #1 chk("raw_first_ready", a_ready, 1);
    tick();
    dispatch(5'd0, 1'b0);
    disp_rs    = 10'd5;
    disp_rs_en = 2'b01;
    #1;
    chk("raw_set", a_raw, 1);
    chk("raw_stall", a_ready, 0);
    chk("raw_count", a_count, 1);
    chk("raw_head", a_rdidx, 5);
    chk("raw_tag", a_tag, 0);
    tick();
    wb_valid = 1'b1;
    #1;
    chk("raw_retiring_still", a_raw, 1);
    chk("raw_retiring_stall", a_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_cleared", a_raw, 0);
    chk("raw_ready_again", a_ready, 1);
    chk("raw_empty", a_empty, 1);
    chk("raw_tag_adv", a_tag, 1);
    tick();
    idle();
    #1 chk("noalloc_count", a_count, 0);

    // Second-source check
    dispatch(5'd7, 1'b1);
    tick();
    idle();
    disp_rs    = {5'd7, 5'd3};
    disp_rs_en = 2'b11;
    #1 chk("src1_raw_en11", a_raw, 1);
    disp_rs_en = 2'b01;
    #1 chk("src1_raw_en01", a_raw, 0);
    disp_rs_en = 2'b10;
    #1 chk("src1_raw_en10", a_raw, 1);
    idle();
    wb_valid = 1'b1;
    tick();
    idle();

    // x0 and wen filtering
    dispatch(5'd0, 1'b1);
    tick();
    dispatch(5'd9, 1'b0);
    tick();
    idle();
    #1;
    chk("filt_count", a_count, 0);
    chk("filt_empty", a_empty, 1);
    dispatch(5'd9, 1'b1);
    tick();
    idle();
    disp_rs    = '0;
    disp_rs_en = 2'b11;
    #1;
    chk("filt_x0_raw", a_raw, 0);
    chk("filt_count1", a_count, 1);
    disp_rs    = {5'd0, 5'd9};
    disp_rs_en = 2'b01;
    #1 chk("filt_rs9_raw", a_raw, 1);
    idle();
    wb_valid = 1'b1;
    tick();
    idle();

    // Fill and stall on full (DEPTH=3)
    exp_q.delete();
    for (int v = 1; v <= 3; v++) begin
      dispatch(AW'(v), 1'b1);
      tick();
      exp_q.push_back(AW'(v));
    end
    idle();
    #1;
    chk("fill_full", a_full, 1);
    chk("fill_count", a_count, 3);
    chk("fill_head", a_rdidx, exp_q[0]);
    dispatch(5'd4, 1'b1);
    #1 chk("fill_stall", a_ready, 0);
    tick();
    #1 chk("fill_count_held", a_count, 3);
    wb_valid = 1'b1;
    #1 chk("fill_retire_stall", a_ready, 0);
    tick();
    void'(exp_q.pop_front());
    wb_valid = 1'b0;
    #1;
    chk("fill_ready_after", a_ready, 1);
    chk("fill_count2", a_count, 2);
    tick();
    exp_q.push_back(5'd4);
    idle();
    #1;
    chk("fill_count3", a_count, 3);
    chk("fill_head2", a_rdidx, exp_q[0]);
    wb_valid = 1'b1;
    tick();
    void'(exp_q.pop_front());
    idle();

    // Ten alloc/retire pairs across the wrap
    for (int j = 0; j < 10; j++) begin
      dispatch(AW'(10 + j), 1'b1);
      wb_valid = 1'b1;
      #1;
      chk("pair_head", a_rdidx, exp_q[0]);
      chk("pair_count", a_count, 2);
      chk("pair_ready", a_ready, 1);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(AW'(10 + j));
    end
    idle();
    while (exp_q.size() > 0) begin
      #1 chk("drain_head", a_rdidx, exp_q[0]);
      wb_valid = 1'b1;
      tick();
      void'(exp_q.pop_front());
      wb_valid = 1'b0;
    end
    #1;
    chk("drain_empty", a_empty, 1);
    chk("drain_count", a_count, 0);

    // WAW check enabled (b) vs disabled (a)
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dispatch(5'd4, 1'b1);
    tick();
    #1;
    chk("waw_b_set", b_waw, 1);
    chk("waw_b_stall", b_ready, 0);
    chk("waw_a_off", a_waw, 0);
    chk("waw_a_ready", a_ready, 1);
    tick();
    idle();
    #1;
    chk("waw_a_count", a_count, 2);
    chk("waw_b_count", b_count, 1);
    dispatch(5'd0, 1'b1);
    #1 chk("waw_b_x0", b_waw, 0);
    idle();

    // Flush overrides alloc/retire; underflow is sticky until reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dispatch(5'd6, 1'b1);
    tick();
    dispatch(5'd7, 1'b1);
    tick();
    idle();
    #1 chk("flush_pre_count", a_count, 2);
    dispatch(5'd8, 1'b1);
    wb_valid = 1'b1;
    flush    = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_empty", a_empty, 1);
    chk("flush_count", a_count, 0);
    chk("flush_full", a_full, 0);
    chk("flush_err_clear", a_err, 0);
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("uflow_set", a_err, 1);
    chk("uflow_count", a_count, 0);
    tick();
    tick();
    #1 chk("uflow_held", a_err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("uflow_survives_flush", a_err, 1);
    rst = 1'b0;
    tick();
    #1;
    chk("uflow_reset", a_err, 0);
    chk("uflow_reset_b", b_err, 0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
